// File: rtl/if_stage_pkg.sv
// Shared encodings and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic                   RSTN_ENABLE = 1'b0;
  localparam logic [INST_ADDR_W-1:0] PC_STEP     = 32'h4;
  localparam logic [INST_W-1:0]      ZERO_WORD   = 32'h0;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} holding buffer for a fetch that completes while decode is stalled.
module if_skid_buf
  import if_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_W,
  parameter int unsigned DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [DATA_W-1:0] load_inst,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst,
  output logic              full
);

  // clear beats load so a flush always empties the entry
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      full <= 1'b0;
      pc   <= '0;
      inst <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      pc   <= load_pc;
      inst <= load_inst;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS32 instruction fetch: owns the PC, fetches over req/ack and fills the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_W,
  parameter int unsigned       DATA_W   = INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              stallreq_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              redir_valid_q, redir_valid_d;
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] inst_d;
  logic              valid_d;
  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic [ADDR_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_inst;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] target_al, flush_al;

  assign target_al = branch_target_i & ALIGN_MASK;
  assign flush_al  = flush_pc_i & ALIGN_MASK;

  // PC after a completed fetch: a pending redirect or a same-cycle branch makes it the delay slot
  assign pc_next = redir_valid_q ? redir_pc_q :
                   branch_flag_i ? target_al  :
                                   fetch_pc_q + ADDR_W'(PC_STEP);

  assign imem_addr_o = fetch_pc_q;
  assign stallreq_o  = (state_q == IF_REQ) & ~imem_ack_i;

  if_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (skid_clear),
    .load_pc   (fetch_pc_q),
    .load_inst (imem_rdata_i),
    .pc        (skid_pc),
    .inst      (skid_inst),
    .full      (skid_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      state_q       <= IF_IDLE;
      fetch_pc_q    <= RESET_PC & ALIGN_MASK;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      kill_q        <= 1'b0;
      imem_req_o    <= 1'b0;
      pc_o          <= '0;
      inst_o        <= DATA_W'(ZERO_WORD);
      inst_valid_o  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      kill_q        <= kill_d;
      imem_req_o    <= (state_d == IF_REQ);
      pc_o          <= pc_d;
      inst_o        <= inst_d;
      inst_valid_o  <= valid_d;
    end
  end

  // Next state; priority is flush > stall > branch. redir_pc also parks the restart PC while killing.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    kill_d        = kill_q;
    pc_d          = pc_o;
    inst_d        = inst_o;
    valid_d       = inst_valid_o;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_clear    = 1'b0;

    if (flush_i) begin
      pc_d          = '0;
      inst_d        = DATA_W'(ZERO_WORD);
      valid_d       = 1'b0;
      skid_clear    = 1'b1;
      redir_valid_d = 1'b0;
      state_d       = IF_REQ;
      if ((state_q == IF_REQ) && !imem_ack_i) begin
        kill_d     = 1'b1;
        redir_pc_d = flush_al;
      end else begin
        kill_d     = 1'b0;
        fetch_pc_d = flush_al;
      end
    end else begin
      unique case (state_q)
        IF_IDLE: state_d = IF_REQ;
        IF_REQ: begin
          if (imem_ack_i && kill_q) begin
            kill_d     = 1'b0;
            fetch_pc_d = redir_pc_q;
            if (!stall_i) begin
              pc_d    = '0;
              inst_d  = DATA_W'(ZERO_WORD);
              valid_d = 1'b0;
            end
          end else if (imem_ack_i) begin
            fetch_pc_d    = pc_next;
            redir_valid_d = 1'b0;
            if (stall_i) begin
              skid_load = 1'b1;
              state_d   = IF_HOLD;
            end else begin
              pc_d    = fetch_pc_q;
              inst_d  = imem_rdata_i;
              valid_d = 1'b1;
            end
          end else begin
            if (branch_flag_i && !kill_q) begin
              redir_valid_d = 1'b1;
              redir_pc_d    = target_al;
            end
            if (!stall_i) begin
              pc_d    = '0;
              inst_d  = DATA_W'(ZERO_WORD);
              valid_d = 1'b0;
            end
          end
        end
        IF_HOLD: begin
          // the skid already holds the delay slot, so a branch retargets the next fetch directly
          if (branch_flag_i) fetch_pc_d = target_al;
          if (!stall_i) begin
            pc_d        = skid_pc;
            inst_d      = skid_inst;
            valid_d     = skid_full;
            skid_unload = 1'b1;
            state_d     = IF_REQ;
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS32 five-stage pipeline, directly upstream of the decode stage.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Registers {pc, inst, valid} into the IF/ID boundary that feeds decode.
- Honours pipeline stall from ctrl, branch redirect from decode (the delay slot is preserved) and exception flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC/instruction address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- stall_i  in  1  from ctrl; hold IF/ID outputs and PC.
- flush_i  in  1  from ctrl; discard all fetched or in-flight work and restart at flush_pc_i.
- flush_pc_i  in  ADDR_W  exception handler / restart address.
- branch_flag_i  in  1  from decode; a taken branch/jump is in ID.
- branch_target_i  in  ADDR_W  branch destination.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_W  fetch address, word aligned.
- imem_ack_i  in  1  fetch complete; imem_rdata_i valid this cycle.
- imem_rdata_i  in  DATA_W  fetched instruction.
- pc_o  out  ADDR_W  IF/ID PC to decode.
- inst_o  out  DATA_W  IF/ID instruction to decode; 0 (NOP) when invalid.
- inst_valid_o  out  1  IF/ID holds a real instruction.
- stallreq_o  out  1  to ctrl; high while a request is outstanding without ack.

Behaviour:
- Reset (async assert, sync release):
  - pc_o=0, inst_o=0, inst_valid_o=0, imem_req_o=0, imem_addr_o=RESET_PC.
  - fetch PC=RESET_PC, skid empty, redirect/kill flags clear, state IDLE.
  - Reset mid-transaction abandons the request; memory must tolerate a dropped req.
- States: IDLE, REQ, HOLD.
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_o=1; imem_addr_o is stable until ack.
    - ack with stall_i=0: latch {addr, rdata, valid=1} into IF/ID at the edge. PC advances to pc+4, or to the pending redirect. Stay in REQ. Zero-wait ack gives 1 instruction per cycle.
    - ack with stall_i=1: capture into the one-entry skid buffer, drop req, go to HOLD.
    - no ack with stall_i=0: IF/ID loads a bubble (inst_o=0, valid=0).
  - HOLD: req=0. When stall_i falls, the skid contents load into IF/ID, the skid empties, and the state returns to REQ.
- Stall: with stall_i=1, pc_o/inst_o/inst_valid_o are frozen. An outstanding request still completes into the skid.
- Branch:
  - The instruction fetched in the same or next completing transaction is the delay slot and is kept.
  - The PC after that delay slot is branch_target_i.
  - If branch_flag_i arrives while waiting for ack, store the target in a redirect register, applied after the delay-slot ack.
  - Repeated branch_flag_i during stall is idempotent.
- Flush (priority flush > stall > branch):
  - At the edge, IF/ID goes to pc=0, inst=0, valid=0; skid and redirect are cleared.
  - If a request is outstanding, set a kill flag. Keep req/addr stable until ack, drop that data, then fetch flush_pc_i.
  - With no outstanding request, the next req uses flush_pc_i in the following cycle.
- Alignment: imem_addr_o[1:0] is forced to 00; target and flush addresses are truncated.
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Outputs: stallreq_o = (state==REQ) & ~imem_ack_i; combinational; never high in IDLE or HOLD.

Decomposition:
- define.v gains:
  - `RstnEnable 1'b0
  - IF state encodings `IF_IDLE, `IF_REQ, `IF_HOLD
  - `PcStep 32'h4
- Existing `InstAddrBus / `InstBus / `ZeroWord are reused for widths and NOP.
- One sub-module, if_skid_buf: one-entry {pc, inst} buffer with load/unload/clear and a full flag.
- The top handles PC, FSM, redirect/kill flags and the IF/ID register.

Test Plan:
1. Reset release, memory always acks same cycle -> addrs 0,4,8,C on consecutive cycles; pc_o/inst_o follow one cycle later; valid=1 from cycle 2.
2. Ack delayed 3 cycles on addr 8 -> stallreq_o high 3 cycles; IF/ID shows 3 bubbles (inst_o=0, valid=0); then pc_o=8.
3. stall_i high 4 cycles; ack for 0x10 arrives during stall -> pc_o frozen at 0xC; req drops after ack; on release pc_o=0x10 with the correct inst; next req addr 0x14.
4. Branch at pc 0x20 in ID (branch_flag_i=1, target 0x100), delay-slot ack delayed 2 cycles -> 0x24 delivered valid; next req addr 0x100, not 0x28.
5. flush_i with flush_pc_i=0x180 while req for 0x40 outstanding -> IF/ID invalid next cycle; 0x40 ack data never appears on inst_o; next req addr 0x180.
6. flush_i, stall_i and branch_flag_i in the same cycle -> flush wins: next fetch 0x180; redirect discarded; PC 0xFFFF_FFFC wraps to 0.
